mc_seq_fsm: RTL and testbench
=============================

Name: mc_seq_fsm

Overview:
- Main sequencing FSM for the 32-bit multicycle ARM-subset core.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and drives the multicycle datapath mux selects and unconditioned write requests.
- Condition gating of RegW/MemW/NextPC/Branch is done downstream by the condition-check logic.
- Adds a memory-ready stall and a fixed-latency iterative-multiply wait.

Parameters:
- MUL_CYCLES, 4, cycles spent in MULEX (range 1..15).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; Funct[5]=I, Funct[0]=L
- mul  in  1  decoded multiply instruction (valid in DECODE)
- mem_ready  in  1  memory access completes this cycle
- IRWrite  out  1  instruction register load
- NextPC  out  1  PC update request
- RegW  out  1  register write request
- MemW  out  1  data memory write request
- Branch  out  1  branch request
- AdrSrc  out  1  0=PC, 1=ALUOut
- ALUSrcA  out  1  0=RD1 reg, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUOp  out  1  1=use Funct decode, 0=ADD
- mul_start  out  1  one-cycle multiplier start pulse
- illegal  out  1  one-cycle undefined-opcode pulse
- state  out  4  current state code (debug)

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, MULEX=10, MULWB=11.
- Codes 12-15 are unreachable; if ever entered, go to FETCH next cycle with all outputs 0.
- Reset (sync): state=FETCH, mul counter=0. All outputs are combinational Moore decode of state (plus mem_ready where noted).
  - In the first cycle after reset, state=0 and outputs are the FETCH values.
  - Reset asserted in any state, including mid-MULEX or a stalled MEMRD, forces FETCH on the next edge and clears the counter.
- Per-state outputs (any output not listed is 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0. IRWrite=NextPC=mem_ready.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
  - MULEX: ALUSrcA=0, ALUSrcB=00; mul_start=1 only when counter==0.
  - MULWB: ResultSrc=00, RegW=1.
- Transitions:
  - FETCH -> DECODE if mem_ready, else stay.
  - DECODE:
    - Op=01 -> MEMADR.
    - Op=00 & mul -> MULEX (mul has priority over Funct[5]).
    - Op=00 & Funct[5] -> EXECI.
    - Op=00 otherwise -> EXECR.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH, with illegal=1 for that DECODE cycle only.
  - MEMADR -> MEMRD if Funct[0], else MEMWR.
  - MEMRD -> MEMWB if mem_ready, else stay.
  - MEMWR -> FETCH if mem_ready, else stay; MemW held 1 while stalled.
  - EXECR/EXECI -> ALUWB.
  - MULEX: counter increments each cycle; -> MULWB when counter==MUL_CYCLES-1, counter cleared on exit.
  - MEMWB, ALUWB, MULWB, BRANCH -> FETCH.
- Counter width: 4 bits.

Test Plan:
- Reset held 2 cycles, then release with mem_ready=1 -> state=0, IRWrite=1, NextPC=1, ALUSrcB=10, all write requests 0.
- ADD reg (Op=00, Funct=001000, mul=0), mem_ready=1 -> states 0,1,6,8,0; RegW=1 only in state 8; ALUOp=1 in state 6.
- LDR then STR (Op=01, Funct[0]=1 then 0), mem_ready=1 -> LDR visits 0,1,2,3,4 with RegW in 4, ResultSrc=01. STR visits 0,1,2,5 with MemW=1 for exactly 1 cycle and AdrSrc=1.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH -> state stays 0, IRWrite=0 for 3 cycles, then IRWrite=1 for 1 cycle, then DECODE.
- MUL (Op=00, mul=1), MUL_CYCLES=4 -> states 0,1,10,10,10,10,11,0; mul_start high only in the first MULEX cycle. Reset asserted in the 3rd MULEX cycle -> FETCH next edge; a following MUL again gives 4 MULEX cycles.
- Op=11 in DECODE -> illegal=1 for 1 cycle, next state FETCH, no RegW/MemW/Branch.

Source files
------------

// File: rtl/mc_seq_fsm.sv
// Main sequencing FSM for the multicycle ARM-subset core: walks each instruction
// through fetch/decode/execute/memory/writeback and decodes datapath selects per state.
module mc_seq_fsm #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       mul,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       mul_start,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        MULEX  = 4'd10,
        MULWB  = 4'd11
    } state_t;

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Only the I and L bits of Funct steer sequencing; the rest go to the ALU decoder.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default at the top of the block,
    // so no path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = FETCH;
        cnt_d   = '0;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = mul ? MULEX : (Funct[5] ? EXECI : EXECR);
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            MULEX: begin
                if (cnt_q == MUL_LAST) begin
                    state_d = MULWB;
                end else begin
                    state_d = MULEX;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        mul_start = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                illegal   = (Op == 2'b11);
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECR:  ALUOp = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            ALUWB:  RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            MULEX:  mul_start = (cnt_q == 4'd0);
            MULWB:  RegW = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_seq_fsm.sv
// Directed bench for mc_seq_fsm: walks each instruction class through its state
// sequence and checks state codes and key control outputs against hand-derived values.
module tb_mc_seq_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mul;
    logic       mem_ready;
    logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUOp;
    logic       mul_start, illegal;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] state;

    int compared   = 0;
    int mismatched = 0;

    mc_seq_fsm #(.MUL_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .mul       (mul),
        .mem_ready (mem_ready),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .mul_start (mul_start),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        Op        = 2'b00;
        Funct     = 6'b001000;
        mul       = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: FETCH with mem_ready high
        check("rst_state", state, 4'd0);
        check("rst_irwrite", {3'b0, IRWrite}, 4'd1);
        check("rst_nextpc", {3'b0, NextPC}, 4'd1);
        check("rst_alusrcb", {2'b0, ALUSrcB}, 4'd2);
        check("rst_alusrca", {3'b0, ALUSrcA}, 4'd1);
        check("rst_resultsrc", {2'b0, ResultSrc}, 4'd2);
        check("rst_writes", {1'b0, RegW, MemW, Branch}, 4'd0);

        // ADD reg: 0,1,6,8,0
        step(); check("add_s1", state, 4'd1);
        check("add_dec_irwrite", {3'b0, IRWrite}, 4'd0);
        step(); check("add_s6", state, 4'd6);
        check("add_execr_aluop", {3'b0, ALUOp}, 4'd1);
        check("add_execr_regw", {3'b0, RegW}, 4'd0);
        check("add_execr_alusrcb", {2'b0, ALUSrcB}, 4'd0);
        step(); check("add_s8", state, 4'd8);
        check("add_aluwb_regw", {3'b0, RegW}, 4'd1);
        check("add_aluwb_aluop", {3'b0, ALUOp}, 4'd0);
        step(); check("add_s0", state, 4'd0);
        check("add_fetch_regw", {3'b0, RegW}, 4'd0);

        // LDR: 0,1,2,3,4,0
        Op = 2'b01; Funct = 6'b000001;
        step(); check("ldr_s1", state, 4'd1);
        step(); check("ldr_s2", state, 4'd2);
        check("ldr_memadr_alusrcb", {2'b0, ALUSrcB}, 4'd1);
        check("ldr_memadr_alusrca", {3'b0, ALUSrcA}, 4'd0);
        step(); check("ldr_s3", state, 4'd3);
        check("ldr_memrd_adrsrc", {3'b0, AdrSrc}, 4'd1);
        // MEMRD stall for 2 cycles
        mem_ready = 1'b0;
        step(); check("ldr_stall1", state, 4'd3);
        step(); check("ldr_stall2", state, 4'd3);
        mem_ready = 1'b1;
        step(); check("ldr_s4", state, 4'd4);
        check("ldr_memwb_regw", {3'b0, RegW}, 4'd1);
        check("ldr_memwb_resultsrc", {2'b0, ResultSrc}, 4'd1);
        step(); check("ldr_s0", state, 4'd0);

        // STR: 0,1,2,5,0 with MemW for exactly one cycle
        Funct = 6'b000000;
        step(); check("str_s1", state, 4'd1);
        step(); check("str_s2", state, 4'd2);
        check("str_memadr_memw", {3'b0, MemW}, 4'd0);
        step(); check("str_s5", state, 4'd5);
        check("str_memwr_memw", {3'b0, MemW}, 4'd1);
        check("str_memwr_adrsrc", {3'b0, AdrSrc}, 4'd1);
        step(); check("str_s0", state, 4'd0);
        check("str_fetch_memw", {3'b0, MemW}, 4'd0);

        // Fetch stall: 3 cycles with IRWrite low, then one IRWrite cycle
        mem_ready = 1'b0;
        #1;
        check("fstall0_state", state, 4'd0);
        check("fstall0_irwrite", {3'b0, IRWrite}, 4'd0);
        step(); check("fstall1_state", state, 4'd0);
        check("fstall1_irwrite", {3'b0, IRWrite}, 4'd0);
        step(); check("fstall2_state", state, 4'd0);
        check("fstall2_nextpc", {3'b0, NextPC}, 4'd0);
        mem_ready = 1'b1;
        #1;
        check("fstall_rel_irwrite", {3'b0, IRWrite}, 4'd1);

        // MUL with MUL_CYCLES=4; Funct[5]=1 to show mul has priority
        Op = 2'b00; mul = 1'b1; Funct = 6'b100000;
        step(); check("mul_s1", state, 4'd1);
        step(); check("mul_ex1", state, 4'd10);
        check("mul_ex1_start", {3'b0, mul_start}, 4'd1);
        check("mul_ex1_alusrcb", {2'b0, ALUSrcB}, 4'd0);
        step(); check("mul_ex2", state, 4'd10);
        check("mul_ex2_start", {3'b0, mul_start}, 4'd0);
        step(); check("mul_ex3", state, 4'd10);
        check("mul_ex3_start", {3'b0, mul_start}, 4'd0);
        step(); check("mul_ex4", state, 4'd10);
        step(); check("mul_wb", state, 4'd11);
        check("mul_wb_regw", {3'b0, RegW}, 4'd1);
        step(); check("mul_s0", state, 4'd0);

        // Reset in the 3rd MULEX cycle, then a clean MUL
        step(); check("mulr_s1", state, 4'd1);
        step(); check("mulr_ex1", state, 4'd10);
        step(); check("mulr_ex2", state, 4'd10);
        step(); check("mulr_ex3", state, 4'd10);
        reset = 1'b1;
        step(); check("mulr_reset_fetch", state, 4'd0);
        reset = 1'b0;
        step(); check("mul2_s1", state, 4'd1);
        step(); check("mul2_ex1", state, 4'd10);
        check("mul2_ex1_start", {3'b0, mul_start}, 4'd1);
        step(); check("mul2_ex2", state, 4'd10);
        step(); check("mul2_ex3", state, 4'd10);
        step(); check("mul2_ex4", state, 4'd10);
        step(); check("mul2_wb", state, 4'd11);
        step(); check("mul2_s0", state, 4'd0);

        // EXECI path: Op=00, Funct[5]=1, mul=0
        mul = 1'b0;
        step(); check("execi_s1", state, 4'd1);
        step(); check("execi_s7", state, 4'd7);
        check("execi_alusrcb", {2'b0, ALUSrcB}, 4'd1);
        step(); check("execi_s8", state, 4'd8);
        step(); check("execi_s0", state, 4'd0);

        // Branch: 0,1,9,0
        Op = 2'b10;
        step(); check("br_s1", state, 4'd1);
        step(); check("br_s9", state, 4'd9);
        check("br_branch", {3'b0, Branch}, 4'd1);
        check("br_resultsrc", {2'b0, ResultSrc}, 4'd2);
        step(); check("br_s0", state, 4'd0);
        check("br_fetch_branch", {3'b0, Branch}, 4'd0);

        // Undefined opcode
        Op = 2'b11;
        step(); check("ill_s1", state, 4'd1);
        check("ill_pulse", {3'b0, illegal}, 4'd1);
        check("ill_writes", {1'b0, RegW, MemW, Branch}, 4'd0);
        step(); check("ill_s0", state, 4'd0);
        check("ill_cleared", {3'b0, illegal}, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
